// File: rtl/golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : golden_nonce_uart_tx
// Description : Buffers golden nonces reported by the miner in a small FIFO
//               and sends each one as four 8N1 UART bytes, MSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  input  logic                     new_golden_nonce,
  input  logic [31:0]              golden_nonce,
  output logic                     uart_tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow
);

  localparam int c_depth = 1 << FIFO_DEPTH_LOG2;
  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0]         c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   c_full     = (FIFO_DEPTH_LOG2 + 1)'(c_depth);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]                r_mem [c_depth];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_overflow;

  // Transmitter state
  state_t                     r_state;
  logic [c_cnt_w-1:0]         r_clk_cnt;
  logic [2:0]                 r_bit_idx;
  logic [1:0]                 r_byte_idx;
  logic [31:0]                r_shift;
  logic                       r_tx;
  logic                       r_busy;

  // Next-state values
  state_t                     w_state_next;
  logic [c_cnt_w-1:0]         w_clk_cnt_next;
  logic [2:0]                 w_bit_next;
  logic [1:0]                 w_byte_next;
  logic [31:0]                w_shift_next;
  logic [7:0]                 w_cur_byte;
  logic                       w_tx_next;

  logic                       w_pop;
  logic                       w_push;
  logic                       w_drop;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a
  // nonce that arrives exactly when the transmitter takes the head.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_push = new_golden_nonce && ((r_count != c_full) || w_pop);
  assign w_drop = new_golden_nonce && !w_push;

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO data array; contents are don't-care until written
  always_ff @(posedge hash_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= golden_nonce;
    end
  end

  // Next-state, bit timing and the registered line level for the next cycle
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_next     = r_bit_idx;
    w_byte_next    = r_byte_idx;
    w_shift_next   = r_shift;
    w_cur_byte     = 8'h00;
    w_tx_next      = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next   = S_START;
          w_clk_cnt_next = '0;
          w_byte_next    = 2'd0;
          w_shift_next   = r_mem[r_rd_ptr];
        end
      end
      S_START: begin
        if (r_clk_cnt == c_cnt_last) begin
          w_state_next   = S_DATA;
          w_clk_cnt_next = '0;
          w_bit_next     = 3'd0;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == c_cnt_last) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == c_cnt_last) begin
          w_clk_cnt_next = '0;
          if (r_byte_idx != 2'd3) begin
            // Next byte moves into the top of the shift register
            w_byte_next  = r_byte_idx + 1'b1;
            w_shift_next = {r_shift[23:0], 8'h00};
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Line level is derived from where the FSM will be, so it can be registered
    w_cur_byte = w_shift_next[31:24];
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_cur_byte[w_bit_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  // FSM state register with registered line and busy outputs
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 2'd0;
      r_shift    <= 32'h0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clk_cnt  <= w_clk_cnt_next;
      r_bit_idx  <= w_bit_next;
      r_byte_idx <= w_byte_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_busy     <= (w_state_next != S_IDLE);
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_golden_nonce_uart_tx
// Description : Scoreboard bench for golden_nonce_uart_tx. A record-level
//               model predicts line/status outputs; a UART decoder rebuilds
//               each transmitted nonce and matches it against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_golden_nonce_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int REC   = 40 * C;

  logic        hash_clk;
  logic        reset;
  logic        new_golden_nonce;
  logic [31:0] golden_nonce;
  logic        uart_tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  golden_nonce_uart_tx #(
    .CLKS_PER_BIT    (C),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .hash_clk         (hash_clk),
    .reset            (reset),
    .new_golden_nonce (new_golden_nonce),
    .golden_nonce     (golden_nonce),
    .uart_tx          (uart_tx),
    .busy             (busy),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  initial begin
    hash_clk = 1'b0;
    forever #5 hash_clk = ~hash_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (record-level timing) ----------------
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_cur   = 32'h0;
  int          m_timer = 0;
  logic        m_ovf   = 1'b0;
  logic        m_tx    = 1'b1;
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  bit          m_pop, m_acc;
  int          e, bp, bb, bj;

  initial forever begin
    @(posedge hash_clk or posedge reset);
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_timer = 0;
      m_ovf   = 1'b0;
      m_tx    = 1'b1;
      m_busy  = 1'b0;
      m_cnt   = 0;
    end else begin
      m_pop = (m_timer == 0) && (mq.size() > 0);
      m_acc = new_golden_nonce && ((mq.size() < DEPTH) || m_pop);
      if (new_golden_nonce && !m_acc) m_ovf = 1'b1;
      if (m_timer > 0) m_timer--;
      if (m_pop) begin
        m_cur   = mq.pop_front();
        m_timer = REC;
        exp_q.push_back(m_cur);
      end
      if (m_acc) mq.push_back(golden_nonce);
      m_busy = (m_timer > 0);
      m_cnt  = mq.size();
      if (m_timer > 0) begin
        e  = REC - m_timer;
        bp = e / C;
        bb = bp / 10;
        bj = bp % 10;
        if (bj == 0)      m_tx = 1'b0;
        else if (bj == 9) m_tx = 1'b1;
        else              m_tx = m_cur[24 - 8*bb + bj - 1];
      end else begin
        m_tx = 1'b1;
      end
    end
  end

  // ---------------- monitor: per-cycle outputs + UART decoder -------------
  int          busy_hi = 0;
  int          peak    = 0;
  bit          dec_active = 0;
  int          dec_k, dec_pos, dec_j;
  logic [7:0]  dec_byte;
  logic [31:0] dec_val;

  initial forever begin
    @(negedge hash_clk);
    if ($time > 2) begin
      check("uart_tx", uart_tx, m_tx);
      check("busy", busy, m_busy);
      check("fifo_count", fifo_count, m_cnt);
      check("overflow", overflow, m_ovf);
      if (busy === 1'b1) busy_hi++;
      if (int'(fifo_count) > peak) peak = fifo_count;

      if (reset) begin
        dec_active = 0;
      end else if (!dec_active) begin
        if (uart_tx === 1'b0) begin
          dec_active = 1;
          dec_k      = 0;
          dec_val    = 32'h0;
          dec_byte   = 8'h00;
        end
      end else begin
        dec_k++;
      end
      if (dec_active && (dec_k % C == C/2)) begin
        dec_pos = dec_k / C;
        dec_j   = dec_pos % 10;
        if (dec_j == 0) check("start_bit", uart_tx, 0);
        else if (dec_j == 9) begin
          check("stop_bit", uart_tx, 1);
          dec_val = {dec_val[23:0], dec_byte};
        end else dec_byte[dec_j-1] = uart_tx;
        if (dec_pos == 39) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL record: actual %0h required none (queue empty)", dec_val);
          end else begin
            check("record", dec_val, exp_q.pop_front());
          end
          dec_active = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+2) ---------------
  task automatic strobe(input logic [31:0] v);
    new_golden_nonce = 1'b1;
    golden_nonce     = v;
    @(posedge hash_clk);
    #2;
    new_golden_nonce = 1'b0;
    golden_nonce     = $urandom;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge hash_clk);
      if (busy === 1'b0 && fifo_count === 3'd0) done = 1;
    end
    check("drain_timeout", done, 1);
    @(posedge hash_clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    check("rst_uart_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    repeat (n) @(posedge hash_clk);
    #2;
    reset = 1'b0;
  endtask

  int  burst_n;
  bit  found;

  initial begin
    new_golden_nonce = 1'b0;
    golden_nonce     = 32'h0;
    reset            = 1'b0;
    #1 reset = 1'b1;

    // Reset defaults with strobes during reset
    repeat (10) begin
      @(posedge hash_clk);
      #2;
      new_golden_nonce = 1'($urandom_range(0, 1));
      golden_nonce     = $urandom;
    end
    @(posedge hash_clk);
    #2;
    new_golden_nonce = 1'b0;
    reset            = 1'b0;
    repeat (30) @(posedge hash_clk);
    #2;

    // Single nonce
    busy_hi = 0;
    strobe(32'h1DAC2B7C);
    wait_idle(400);
    check("t1_busy_cycles", busy_hi, REC);

    // Overflow: seven consecutive strobes
    peak = 0;
    for (int v = 1; v <= 7; v++) strobe(v);
    wait_idle(1200);
    check("t3_overflow", overflow, 1);
    check("t3_peak_count", peak, DEPTH);
    do_reset(3);

    // Back-to-back records
    strobe(32'hAAAAAAAA);
    strobe(32'h00000001);
    wait_idle(500);

    // Reset mid-frame while the second byte's data bits are on the line
    strobe({8'($urandom), 8'h00, 16'($urandom)});
    strobe($urandom);
    strobe($urandom);
    repeat (55) @(posedge hash_clk);
    #2;
    check("t5_busy_before", busy, 1);
    check("t5_count_before", fifo_count, 2);
    check("t5_line_low", uart_tx, 0);
    do_reset(2);
    repeat (50) @(posedge hash_clk);
    #2;
    check("t5_line_idle", uart_tx, 1);

    // Push on the exact IDLE pop cycle with the FIFO full
    strobe($urandom);
    repeat (4) strobe($urandom);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge hash_clk);
      if (busy === 1'b0) found = 1;
    end
    check("t6_wait_idle", found, 1);
    check("t6_full_before", fifo_count, 4);
    new_golden_nonce = 1'b1;
    golden_nonce     = $urandom;
    @(posedge hash_clk);
    #2;
    new_golden_nonce = 1'b0;
    @(negedge hash_clk);
    check("t6_count_kept", fifo_count, 4);
    check("t6_no_overflow", overflow, 0);
    @(posedge hash_clk);
    #2;
    wait_idle(1200);

    // Randomized traffic with bursts
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        burst_n = $urandom_range(1, 6);
        repeat (burst_n) strobe($urandom);
      end else begin
        @(posedge hash_clk);
        #2;
      end
    end
    wait_idle(2500);

    check("end_queue_empty", exp_q.size(), 0);
    check("end_decoder_idle", dec_active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
- Host-facing result path for fpgaminer_top. Consumes the new_golden_nonce / golden_nonce pulse interface that the miner drives.
- Buffers found nonces in a small FIFO and serializes each one over a UART transmit line (8N1) so the host can read results.
- Sits beside fpgaminer_top in the same hash_clk domain and is the receiving end of the miner's result interface.

Parameters:
- CLKS_PER_BIT, 868, hash_clk cycles per UART bit (100 MHz / 115200); minimum legal value is 2.
- FIFO_DEPTH_LOG2, 2, log2 of nonce FIFO depth (default depth 4 entries of 32 bits).

Ports:
- hash_clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- new_golden_nonce  input  1  one-cycle strobe; golden_nonce is valid in that cycle.
- golden_nonce  input  32  nonce value from the miner, as presented (no byteswap applied).
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high while a 4-byte record is being transmitted.
- fifo_count  output  FIFO_DEPTH_LOG2+1  number of nonces queued, excluding the one in flight.
- overflow  output  1  sticky; set when a nonce is dropped because the FIFO is full.

Behaviour:
- Reset is one clock and asynchronous, active-high. Asserting reset forces uart_tx=1, busy=0, fifo_count=0 and overflow=0 immediately.
- Reset clears the FIFO and returns the FSM to IDLE. Reset asserted mid-frame aborts the frame; no partial byte resumes after reset.
- FIFO push: on a rising edge with new_golden_nonce=1 and the FIFO not full, golden_nonce is written.
- FIFO full: if new_golden_nonce=1 and the FIFO is full, the value is dropped and overflow is set to 1. overflow is cleared only by reset.
- Pop and push in the same edge: both happen. fifo_count is unchanged. A push when full and a pop on the same edge is accepted (no drop).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1, busy=0.
  - If fifo_count>0, pop the head into a 32-bit shift register, set byte index=0 and go to START. busy=1 from this edge.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - uart_tx=1 for CLKS_PER_BIT cycles.
  - If byte index<3: increment it and go to START. There is no extra idle between bytes.
  - Otherwise go to IDLE with busy=0.
- Byte order: golden_nonce[31:24] is sent first, then [23:16], [15:8], [7:0].
- Record length: 40 bit-times = 40*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- Back-to-back records: IDLE lasts exactly 1 cycle (uart_tx=1) before the next pop.
- Latency with the FIFO empty and the FSM in IDLE:
  - The strobe is captured on edge N.
  - The pop happens on edge N+1.
  - uart_tx goes low on edge N+1, so the start bit begins 1 cycle after capture.
- Bit-timer and byte counters wrap only through explicit state transitions. No free-running counters.
- All outputs are registered (uart_tx is glitch-free).

Test Plan:
1. Single nonce: CLKS_PER_BIT=4, one strobe with golden_nonce=32'h1DAC2B7C.
   - Required: bytes 1D, AC, 2B, 7C on uart_tx.
   - First byte bit sequence: 0 (start), 1,0,1,1,1,0,0,0, 1 (stop), each bit held 4 cycles.
   - busy high for exactly 160 cycles. fifo_count stays 0.
2. Reset defaults: hold reset high for 10 cycles, with strobes applied during reset.
   - Required: uart_tx=1, busy=0, fifo_count=0 and overflow=0 throughout.
   - Nothing is transmitted after release.
3. Overflow: default depth 4, strobes on 7 consecutive cycles with values 1..7.
   - Required: records 1,2,3,4,5 are transmitted in order, and 6 and 7 are dropped.
   - overflow=1 from the edge capturing 6. Peak fifo_count=4.
4. Back-to-back records: two strobes (32'hAAAAAAAA, then 32'h00000001) one cycle apart.
   - Required: the second record's start bit begins exactly 1 cycle after the first record's last stop-bit cycle.
   - Total of 80 bit-times.
5. Reset mid-frame: assert reset during DATA of byte 2 with 2 nonces queued.
   - Required: uart_tx=1 immediately and fifo_count=0.
   - After release, uart_tx stays high until a new strobe arrives.
6. Simultaneous pop/push when full: fill the FIFO to 4 while transmitting, then strobe on the exact IDLE pop cycle.
   - Required: the nonce is accepted, fifo_count remains 4, and overflow stays 0.
